// File: rtl/onewire_slave.sv
// 1-Wire slave PHY: reset/presence handling, write-slot sampling and read-slot
// driving. Define ONEWIRE_SLAVE_GLITCH_FILTER_EN to reject lows of 2 cycles or fewer.
module onewire_slave #(
  parameter int CLK_PER_US = 10
) (
  input  logic       clk,
  input  logic       arst_n,
  inout  wire        onewire,
  input  logic [7:0] tx_dat,
  input  logic       tx_we,
  output logic       tx_rdy,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       reset_det
);

  localparam logic [15:0] T_RST = 16'(480 * CLK_PER_US);
  localparam logic [15:0] T_PW  = 16'(30 * CLK_PER_US);
  localparam logic [15:0] T_PD  = 16'(120 * CLK_PER_US);
  localparam logic [15:0] T_SMP = 16'(30 * CLK_PER_US);

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_DRIVE, SLOT_WAIT, WR_SAMPLE, RD_DRIVE, SLOT_END
  } state_t;

  state_t      state, state_nxt;
  logic        s1, s2, line, line_d;
  logic        fall, rise, rst_det;
  logic [15:0] low_cnt, tmr;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sh, tx_sh;
  logic        tx_full;
  logic        wr_smp, rd_adv, drv_q;

  // Released bus idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= onewire;
      s2 <= s1;
    end
  end

`ifdef ONEWIRE_SLAVE_GLITCH_FILTER_EN
  logic       line_q;
  logic [1:0] flt_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      line_q  <= 1'b1;
      flt_cnt <= 2'd0;
    end else if (s2 == line_q) begin
      flt_cnt <= 2'd0;
    end else if (flt_cnt == 2'd2) begin
      line_q  <= s2;
      flt_cnt <= 2'd0;
    end else begin
      flt_cnt <= flt_cnt + 2'd1;
    end
  end

  assign line = line_q;
`else
  assign line = s2;
`endif

  assign fall    = line_d & ~line;
  assign rise    = ~line_d & line;
  assign rst_det = rise && (low_cnt >= T_RST);
  assign tx_rdy  = ~tx_full && (bit_cnt == 3'd0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      line_d  <= 1'b1;
      low_cnt <= 16'd0;
    end else begin
      line_d <= line;
      if (fall)
        low_cnt <= 16'd0;
      else if (!line && low_cnt != 16'hFFFF)
        low_cnt <= low_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_smp    = 1'b0;
    rd_adv    = 1'b0;
    case (state)
      IDLE:       state_nxt = IDLE;
      PRES_WAIT:  if (tmr == T_PW - 16'd1) state_nxt = PRES_DRIVE;
      PRES_DRIVE: if (tmr == T_PD - 16'd1) state_nxt = SLOT_WAIT;
      SLOT_WAIT:  if (fall) state_nxt = tx_full ? RD_DRIVE : WR_SAMPLE;
      WR_SAMPLE: begin
        if (tmr == T_SMP - 16'd1) begin
          wr_smp    = 1'b1;
          state_nxt = SLOT_END;
        end
      end
      RD_DRIVE: begin
        if (tmr == T_SMP - 16'd1) begin
          rd_adv    = 1'b1;
          state_nxt = SLOT_END;
        end
      end
      SLOT_END:   if (line) state_nxt = SLOT_WAIT;
      default:    state_nxt = IDLE;
    endcase
    // A completed reset pulse overrides whatever slot was in progress.
    if (rst_det) begin
      state_nxt = PRES_WAIT;
      wr_smp    = 1'b0;
      rd_adv    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      tmr   <= 16'd0;
      drv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rst_det || state_nxt != state)
        tmr <= 16'd0;
      else if (tmr != 16'hFFFF)
        tmr <= tmr + 16'd1;
      // Registered drive decoded from next state keeps the pad glitch-free.
      drv_q <= (state_nxt == PRES_DRIVE) || (state_nxt == RD_DRIVE && !tx_sh[0]);
    end
  end

  assign onewire = drv_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      tx_full   <= 1'b0;
      rx_dat    <= 8'h00;
      rx_vld    <= 1'b0;
      reset_det <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      reset_det <= rst_det;
      if (rst_det) begin
        bit_cnt <= 3'd0;
        rx_sh   <= 8'h00;
        tx_sh   <= 8'h00;
        tx_full <= 1'b0;
      end else begin
        if (tx_we && tx_rdy) begin
          tx_sh   <= tx_dat;
          tx_full <= 1'b1;
        end
        if (wr_smp) begin
          rx_sh   <= {line, rx_sh[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_dat <= {line, rx_sh[7:1]};
            rx_vld <= 1'b1;
          end
        end
        if (rd_adv) begin
          tx_sh   <= {1'b0, tx_sh[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            tx_full <= 1'b0;
        end
      end
    end
  end

endmodule
